// File: rtl/bcd_gray_rr_sched_pkg.sv
// Shared definitions for the round-robin BCD-to-Gray converter scheduler:
// FSM encodings, digit range limit and the code reported for rejected digits.
package bcd_gray_rr_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] ERR_GRAY = 4'b0000;

  function automatic logic bcd_invalid(input logic [3:0] digit);
    return (digit > BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_gray_rr_sched_rr_pick.sv
// Combinational rotating-priority picker: the first asserted request at or
// above ptr_i (wrapping at NREQ) wins, reported as one-hot, binary id and any.
module bcd_rr_pick
  import bcd_gray_rr_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  id_o,
  output logic            any_o
);

  localparam int SW = IDW + 1;

  logic [SW-1:0]  sum_s;
  logic [IDW-1:0] idx_s;
  logic           hit_s;

  // Walk the requesters in rotated order; the first hit masks all later ones.
  always_comb begin
    grant_o = {NREQ{1'b0}};
    id_o    = {IDW{1'b0}};
    any_o   = 1'b0;
    sum_s   = {SW{1'b0}};
    idx_s   = {IDW{1'b0}};
    hit_s   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      sum_s = {1'b0, ptr_i} + SW'(k);
      if (sum_s >= SW'(NREQ)) begin
        sum_s = sum_s - SW'(NREQ);
      end else begin
        sum_s = sum_s;
      end
      idx_s          = sum_s[IDW-1:0];
      hit_s          = req_i[idx_s] & ~any_o;
      grant_o[idx_s] = grant_o[idx_s] | hit_s;
      id_o           = hit_s ? idx_s : id_o;
      any_o          = any_o | hit_s;
    end
  end

endmodule

// File: rtl/bcd_gray_rr_sched.sv
// Time-shares one external BCD-to-Gray converter among NREQ requesters with
// round-robin arbitration and a registered, back-pressured result port.
module bcd_gray_rr_sched
  import bcd_gray_rr_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_bcd,
  output logic [NREQ-1:0]   req_ready,
  output logic [3:0]        cnv_bcd,
  input  logic [3:0]        cnv_gray,
  output logic              out_valid,
  output logic [3:0]        out_gray,
  output logic [IDW-1:0]    out_id,
  output logic              out_err,
  input  logic              out_ready
);

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] held_id_q, held_id_d;
  logic [3:0]     held_bcd_q, held_bcd_d;
  logic           out_valid_q, out_valid_d;
  logic [3:0]     out_gray_q, out_gray_d;
  logic [IDW-1:0] out_id_q, out_id_d;
  logic           out_err_q, out_err_d;

  logic [NREQ-1:0] grant_s;
  logic [IDW-1:0]  grant_id_s;
  logic            any_s;
  logic [3:0]      sel_bcd_s;

  bcd_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant_s),
    .id_o    (grant_id_s),
    .any_o   (any_s)
  );

  // Select the winner's digit with an AND-OR mux over the one-hot grant.
  always_comb begin
    sel_bcd_s = 4'd0;
    for (int k = 0; k < NREQ; k++) begin
      sel_bcd_s = sel_bcd_s | (req_bcd[4*k +: 4] & {4{grant_s[k]}});
    end
  end

  // Next-state logic for the IDLE -> CONV -> HOLD sequence.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    held_id_d   = held_id_q;
    held_bcd_d  = held_bcd_q;
    out_valid_d = out_valid_q;
    out_gray_d  = out_gray_q;
    out_id_d    = out_id_q;
    out_err_d   = out_err_q;
    case (state_q)
      ST_IDLE: begin
        if (any_s) begin
          held_bcd_d = sel_bcd_s;
          held_id_d  = grant_id_s;
          state_d    = ST_CONV;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_CONV: begin
        out_gray_d  = bcd_invalid(held_bcd_q) ? ERR_GRAY : cnv_gray;
        out_err_d   = bcd_invalid(held_bcd_q);
        out_id_d    = held_id_q;
        out_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          // Wrap at NREQ, which differs from 2^IDW when NREQ is not a power of two.
          ptr_d       = (out_id_q == IDW'(NREQ - 1)) ? {IDW{1'b0}} : out_id_q + IDW'(1);
          state_d     = ST_IDLE;
        end else begin
          state_d     = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= {IDW{1'b0}};
      held_id_q   <= {IDW{1'b0}};
      held_bcd_q  <= 4'd0;
      out_valid_q <= 1'b0;
      out_gray_q  <= 4'd0;
      out_id_q    <= {IDW{1'b0}};
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      held_id_q   <= held_id_d;
      held_bcd_q  <= held_bcd_d;
      out_valid_q <= out_valid_d;
      out_gray_q  <= out_gray_d;
      out_id_q    <= out_id_d;
      out_err_q   <= out_err_d;
    end
  end

  // The held digit only changes on accept, so the converter input is quiet outside CONV.
  assign cnv_bcd   = held_bcd_q;
  assign req_ready = (rst_n && (state_q == ST_IDLE)) ? grant_s : {NREQ{1'b0}};
  assign out_valid = out_valid_q;
  assign out_gray  = out_gray_q;
  assign out_id    = out_id_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_bcd_gray_rr_sched.sv
// Directed scoreboard bench for bcd_gray_rr_sched with a behavioural
// BCD-to-Gray converter on the cnv_* ports.
module tb_bcd_gray_rr_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [4*NREQ-1:0] req_bcd;
  logic [NREQ-1:0]   req_ready;
  logic [3:0]        cnv_bcd;
  logic [3:0]        cnv_gray;
  logic              out_valid;
  logic [3:0]        out_gray;
  logic [IDW-1:0]    out_id;
  logic              out_err;
  logic              out_ready;

  logic [3:0] dig [NREQ];

  typedef struct packed {
    logic [3:0]     gray;
    logic [IDW-1:0] id;
    logic           err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  assign req_bcd  = {dig[3], dig[2], dig[1], dig[0]};
  assign cnv_gray = cnv_bcd ^ {1'b0, cnv_bcd[3:1]};

  bcd_gray_rr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_bcd   (req_bcd),
    .req_ready (req_ready),
    .cnv_bcd   (cnv_bcd),
    .cnv_gray  (cnv_gray),
    .out_valid (out_valid),
    .out_gray  (out_gray),
    .out_id    (out_id),
    .out_err   (out_err),
    .out_ready (out_ready)
  );

  function automatic logic [3:0] model_gray(input logic [3:0] d);
    if (d > 4'd9) return 4'b0000;
    else          return d ^ {1'b0, d[3:1]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Pop and compare on a result handshake, then advance to just after the next falling edge.
  task automatic nstep();
    exp_t e;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      total++;
      assert (sb.size() > 0) else begin
        bad++;
        $error("FAIL sb_underflow: observed=result expected=none");
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_gray", 32'(out_gray), 32'(e.gray));
        chk("sb_id",   32'(out_id),   32'(e.id));
        chk("sb_err",  32'(out_err),  32'(e.err));
      end
    end
    @(negedge clk);
    #1;
  endtask

  // Wait a bounded number of cycles for a grant, check its target, queue the expected result.
  task automatic grant_wait(input int exp_id, input int budget);
    bit   got;
    exp_t e;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      #1;
      if (req_ready !== 4'b0000) begin
        got = 1'b1;
        chk("grant", 32'(req_ready), 32'(1) << exp_id);
        e.gray = model_gray(dig[exp_id]);
        e.id   = IDW'(exp_id);
        e.err  = (dig[exp_id] > 4'd9);
        sb.push_back(e);
      end
      nstep();
    end
    total++;
    assert (got) else begin
      bad++;
      $error("FAIL grant_timeout: observed=none expected=requester %0d", exp_id);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && sb.size() > 0; i++) nstep();
    chk("drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    out_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) dig[i] = 4'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_gray",  32'(out_gray),  32'd0);
    chk("rst_id",    32'(out_id),    32'd0);
    chk("rst_err",   32'(out_err),   32'd0);
    chk("rst_cnv",   32'(cnv_bcd),   32'd0);
    rst_n = 1'b1;
    nstep();

    // Single request from requester 2.
    dig[2] = 4'd3; req_valid = 4'b0100; out_ready = 1'b1;
    grant_wait(2, 4);
    chk("single_ready_drop", 32'(req_ready), 32'd0);
    chk("single_conv_valid", 32'(out_valid), 32'd0);
    chk("single_cnv_bcd",    32'(cnv_bcd),   32'd3);
    req_valid = 4'b0000;
    nstep();
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_gray",  32'(out_gray),  32'b0010);
    chk("single_id",    32'(out_id),    32'd2);
    chk("single_err",   32'(out_err),   32'd0);
    nstep();

    // Reset while a result is held.
    dig[1] = 4'd4; req_valid = 4'b0010; out_ready = 1'b0;
    grant_wait(1, 4);
    req_valid = 4'b0000;
    nstep();
    chk("hold_before_rst_valid", 32'(out_valid), 32'd1);
    chk("hold_before_rst_id",    32'(out_id),    32'd1);
    dig[0] = 4'd1; dig[1] = 4'd2; dig[2] = 4'd3; dig[3] = 4'd1;
    req_valid = 4'b1111;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_ready", 32'(req_ready), 32'd0);
    chk("async_rst_gray",  32'(out_gray),  32'd0);
    chk("async_rst_id",    32'(out_id),    32'd0);
    sb.delete();
    nstep();
    nstep();
    rst_n = 1'b1; out_ready = 1'b1;

    // Round robin with everyone requesting; first grant after reset is requester 0.
    grant_wait(0, 4);
    grant_wait(1, 6);
    grant_wait(2, 6);
    grant_wait(3, 6);
    grant_wait(0, 6);
    req_valid = 4'b0000;
    drain();

    // Out-of-range digit from requester 1.
    dig[1] = 4'd12; req_valid = 4'b0010;
    grant_wait(1, 6);
    req_valid = 4'b0000;
    nstep();
    chk("bad_digit_err",  32'(out_err),  32'd1);
    chk("bad_digit_gray", 32'(out_gray), 32'b0000);
    chk("bad_digit_id",   32'(out_id),   32'd1);
    nstep();

    // Pointer now 2; backpressure held for ten cycles.
    dig[0] = 4'd5; dig[1] = 4'd6; dig[2] = 4'd7; dig[3] = 4'd8;
    req_valid = 4'b1111; out_ready = 1'b0;
    grant_wait(2, 4);
    nstep();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_gray",  32'(out_gray),  32'b0100);
      chk("bp_id",    32'(out_id),    32'd2);
      chk("bp_err",   32'(out_err),   32'd0);
      chk("bp_ready", 32'(req_ready), 32'd0);
      nstep();
    end
    out_ready = 1'b1; req_valid = 4'b0001;
    nstep();
    chk("bp_valid_drop", 32'(out_valid), 32'd0);

    // Pointer is 3 with only requester 0 valid: wrap-around grant.
    grant_wait(0, 2);
    dig[1] = 4'd9; dig[3] = 4'd9;
    req_valid = 4'b1010;
    chk("busy_ready", 32'(req_ready), 32'd0);
    nstep();
    req_valid = 4'b1000;
    nstep();
    grant_wait(3, 2);
    req_valid = 4'b0000;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
